conv_mac_scheduler: RTL and testbench



---
 rtl/conv_mac_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_conv_mac_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_scheduler.sv
// conv_mac_scheduler: sequencer for the shared single-MAC conv2d datapath.
// Walks every 3x3 same-padded window in row-major order. For each output
// position it issues NUM_FILT*9 MAC cycles (filter outer, tap inner) and then
// one commit beat, using a valid/ready handshake toward the post-processing
// pipeline. All outputs are registered from the next-state values, so the
// addresses and controls line up with mac_en in the same cycle.
module conv_mac_scheduler #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int NUM_FILT = 2,
  parameter int PIX_AW   = 6,
  parameter int W_AW     = 5,
  parameter int FILT_W   = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [PIX_AW-1:0] pix_addr,
  output logic              pad,
  output logic [W_AW-1:0]   w_addr,
  output logic [FILT_W-1:0] filt_idx,
  output logic              mac_en,
  output logic              mac_first,
  output logic              out_valid,
  output logic [PIX_AW-1:0] out_pos,
  output logic              out_last
);

  // Column / row counter widths, and a signed coordinate width that can hold
  // -1 .. max(IMG_W, IMG_H) without wrapping.
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int MAXWH = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW    = $clog2(MAXWH + 1) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MAC    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [PIX_AW-1:0] POS_LAST  = PIX_AW'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(NUM_FILT - 1);
  localparam logic [3:0]        TAP_LAST  = 4'd8;

  localparam logic signed [CW-1:0] IMG_W_S = CW'(IMG_W);
  localparam logic signed [CW-1:0] IMG_H_S = CW'(IMG_H);
  localparam logic [PIX_AW-1:0]    IMG_W_P = PIX_AW'(IMG_W);

  logic [1:0]        r_state;
  logic [PIX_AW-1:0] r_pos;
  logic [XW-1:0]     r_ox;
  logic [YW-1:0]     r_oy;
  logic [FILT_W-1:0] r_filt;
  logic [3:0]        r_tap;

  logic [1:0]        w_state_next;
  logic [PIX_AW-1:0] w_pos_next;
  logic [XW-1:0]     w_ox_next;
  logic [YW-1:0]     w_oy_next;
  logic [FILT_W-1:0] w_filt_next;
  logic [3:0]        w_tap_next;

  logic [1:0]           w_kx;
  logic [1:0]           w_ky;
  logic signed [CW-1:0] w_x;
  logic signed [CW-1:0] w_y;
  logic                 w_pad;
  logic [PIX_AW-1:0]    w_pix;
  logic [W_AW-1:0]      w_waddr;

  // Next-state and counter sequencing; abort overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_ox_next    = r_ox;
    w_oy_next    = r_oy;
    w_filt_next  = r_filt;
    w_tap_next   = r_tap;
    if (abort) begin
      w_state_next = S_IDLE;
      w_pos_next   = '0;
      w_ox_next    = '0;
      w_oy_next    = '0;
      w_filt_next  = '0;
      w_tap_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_next = S_MAC;
            w_pos_next   = '0;
            w_ox_next    = '0;
            w_oy_next    = '0;
            w_filt_next  = '0;
            w_tap_next   = '0;
          end
        end
        S_MAC: begin
          if (r_tap == TAP_LAST) begin
            w_tap_next = '0;
            if (r_filt == FILT_LAST) begin
              w_filt_next  = '0;
              w_state_next = S_COMMIT;
            end else begin
              w_filt_next = r_filt + FILT_W'(1);
            end
          end else begin
            w_tap_next = r_tap + 4'd1;
          end
        end
        S_COMMIT: begin
          if (out_ready) begin
            if (r_pos == POS_LAST) begin
              w_state_next = S_DONE;
            end else begin
              w_state_next = S_MAC;
              w_pos_next   = r_pos + PIX_AW'(1);
              w_filt_next  = '0;
              w_tap_next   = '0;
              if (r_ox == X_LAST) begin
                w_ox_next = '0;
                w_oy_next = r_oy + YW'(1);
              end else begin
                w_ox_next = r_ox + XW'(1);
              end
            end
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
          w_pos_next   = '0;
          w_ox_next    = '0;
          w_oy_next    = '0;
          w_filt_next  = '0;
          w_tap_next   = '0;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Tap geometry for the upcoming MAC cycle: padding test and buffer address.
  always_comb begin
    w_ky    = 2'(w_tap_next / 4'd3);
    w_kx    = 2'(w_tap_next % 4'd3);
    w_x     = CW'(w_ox_next) + CW'(w_kx) - CW'(1);
    w_y     = CW'(w_oy_next) + CW'(w_ky) - CW'(1);
    w_pad   = w_x[CW-1] | w_y[CW-1] | (w_x >= IMG_W_S) | (w_y >= IMG_H_S);
    w_pix   = PIX_AW'(w_y) * IMG_W_P + PIX_AW'(w_x);
    w_waddr = W_AW'(w_filt_next) * W_AW'(9) + W_AW'(w_tap_next);
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pos     <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_filt    <= '0;
      r_tap     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_addr  <= '0;
      pad       <= 1'b0;
      w_addr    <= '0;
      filt_idx  <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_last  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pos     <= w_pos_next;
      r_ox      <= w_ox_next;
      r_oy      <= w_oy_next;
      r_filt    <= w_filt_next;
      r_tap     <= w_tap_next;
      busy      <= (w_state_next != S_IDLE);
      done      <= (w_state_next == S_DONE);
      mac_en    <= (w_state_next == S_MAC);
      mac_first <= (w_state_next == S_MAC) && (w_tap_next == 4'd0);
      pad       <= (w_state_next == S_MAC) && w_pad;
      pix_addr  <= ((w_state_next == S_MAC) && !w_pad) ? w_pix : '0;
      w_addr    <= (w_state_next == S_MAC) ? w_waddr : '0;
      filt_idx  <= (w_state_next == S_MAC) ? w_filt_next : '0;
      out_valid <= (w_state_next == S_COMMIT);
      out_pos   <= (w_state_next == S_COMMIT) ? w_pos_next : '0;
      out_last  <= (w_state_next == S_COMMIT) && (w_pos_next == POS_LAST);
    end
  end

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Self-checking bench for conv_mac_scheduler: full-image passes checked as
// streams of MAC beats and commit beats against window arithmetic, a table of
// hand-computed tap vectors, and directed abort/reset/start corner cases.
module tb_conv_mac_scheduler;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int NF    = 2;
  localparam int N     = W * H;
  localparam int BPP   = NF * 9;
  localparam int P     = BPP + 1;
  localparam int LIMIT = N * P * 3 + 500;

  logic       clk = 1'b0;
  logic       reset, start, abort, out_ready;
  logic       busy, done, pad, mac_en, mac_first, out_valid, out_last;
  logic [5:0] pix_addr, out_pos;
  logic [4:0] w_addr;
  logic [0:0] filt_idx;

  int tests  = 0;
  int failed = 0;
  int obs_pad [N][9];
  int obs_addr[N][9];

  typedef struct {
    int pos;
    int tap;
    int pad;
    int addr;
  } vec_t;
  vec_t vecs[16];

  conv_mac_scheduler #(.IMG_W(W), .IMG_H(H), .NUM_FILT(NF), .PIX_AW(6), .W_AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
    .busy(busy), .done(done), .pix_addr(pix_addr), .pad(pad), .w_addr(w_addr),
    .filt_idx(filt_idx), .mac_en(mac_en), .mac_first(mac_first), .out_valid(out_valid),
    .out_pos(out_pos), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint all_outs();
    return longint'({busy, done, mac_en, mac_first, out_valid, out_last, pad,
                     pix_addr, w_addr, filt_idx, out_pos});
  endfunction

  // Window arithmetic straight from the definition of a same-padded 3x3 tap.
  function automatic void ref_tap(input int pos, input int tap, output int epad, output int eaddr);
    int ox, oy, x, y;
    ox = pos % W;
    oy = pos / W;
    x  = ox + tap % 3 - 1;
    y  = oy + tap / 3 - 1;
    epad  = (x < 0 || x >= W || y < 0 || y >= H) ? 1 : 0;
    eaddr = epad ? 0 : y * W + x;
  endfunction

  // One pass from start. mode 0: ready always high; mode 1: random ready with
  // a 5-cycle hold at the pos 3 commit. spur_pos: pulse start while busy there.
  // abort_beat: raise abort after that MAC beat and check the cancel.
  task automatic run_pass(input int mode, input int spur_pos, input int abort_beat);
    int beat, commits, stalls, cyc, hold3, ep, ef, et, epad, eaddr, bad;
    bit prev_stall, prev_xfer, prev_last, finished;
    beat = 0; commits = 0; stalls = 0; hold3 = 0;
    prev_stall = 0; prev_xfer = 0; prev_last = 0; finished = 0;
    start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < LIMIT) begin
      if (prev_stall) check("hold_valid", out_valid, 1);
      if (prev_xfer && !prev_last) check("resume_mac", mac_en, 1);
      if (prev_xfer && prev_last) check("done_after_last", done, 1);
      prev_stall = 0; prev_xfer = 0; prev_last = 0;
      start = 1'b0;
      if (done) begin
        check("done_cycle", cyc, N * P + stalls + 1);
        check("done_busy", busy, 1);
        check("mac_beats", beat, N * BPP);
        check("commit_beats", commits, N);
        step();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        finished = 1;
      end else begin
        check("busy", busy, 1);
        if (mode == 0) out_ready = 1'b1;
        else if (out_valid && commits == 3 && hold3 < 5) out_ready = 1'b0;
        else out_ready = 1'($urandom_range(0, 1));
        if (mac_en) begin
          ep = beat / BPP;
          ef = (beat % BPP) / 9;
          et = beat % 9;
          ref_tap(ep, et, epad, eaddr);
          if (beat == 0) check("first_mac_cycle", cyc, 1);
          check("mac_pad", pad, epad);
          check("mac_pix_addr", pix_addr, eaddr);
          check("mac_w_addr", w_addr, ef * 9 + et);
          check("mac_filt", filt_idx, ef);
          check("mac_first", mac_first, (et == 0) ? 1 : 0);
          check("mac_no_valid", out_valid, 0);
          if (ef == 0) begin
            obs_pad[ep][et]  = pad;
            obs_addr[ep][et] = pix_addr;
          end
          if (spur_pos >= 0 && ep == spur_pos && ef == 0 && et == 0) start = 1'b1;
          beat++;
        end
        if (out_valid) begin
          check("commit_pos", out_pos, commits);
          check("commit_last", out_last, (commits == N - 1) ? 1 : 0);
          check("commit_no_mac", mac_en, 0);
          if (out_ready) begin
            prev_xfer = 1;
            prev_last = (commits == N - 1);
            commits++;
          end else begin
            prev_stall = 1;
            stalls++;
            if (commits == 3) hold3++;
          end
        end
        if (abort_beat >= 0 && mac_en && beat - 1 == abort_beat) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          check("abort_clears", all_outs(), 0);
          bad = 0;
          for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) bad++;
          end
          check("abort_no_done", bad, 0);
          finished = 1;
        end else begin
          step();
          cyc++;
        end
      end
    end
    if (!finished) check("pass_timeout", 0, 1);
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int k, epad, eaddr;
    vecs[0]  = '{0, 0, 1, 0};
    vecs[1]  = '{0, 4, 0, 0};
    vecs[2]  = '{0, 8, 0, 9};
    vecs[3]  = '{63, 0, 0, 54};
    vecs[4]  = '{63, 1, 0, 55};
    vecs[5]  = '{63, 2, 1, 0};
    vecs[6]  = '{63, 3, 0, 62};
    vecs[7]  = '{63, 4, 0, 63};
    vecs[8]  = '{63, 5, 1, 0};
    vecs[9]  = '{63, 6, 1, 0};
    vecs[10] = '{63, 7, 1, 0};
    vecs[11] = '{63, 8, 1, 0};
    vecs[12] = '{7, 2, 1, 0};
    vecs[13] = '{56, 3, 1, 0};
    vecs[14] = '{9, 0, 0, 0};
    vecs[15] = '{12, 7, 0, 20};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    check("reset_outs", all_outs(), 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    step();
    check("idle_outs", all_outs(), 0);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    step();
    check("start_abort_idle", all_outs(), 0);
    start = 1'b0; abort = 1'b0;
    step();
    check("still_idle", busy, 0);

    // Full pass, ready high, then the hand-computed tap table
    run_pass(0, -1, -1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("vec%0d_pad", i), obs_pad[vecs[i].pos][vecs[i].tap], vecs[i].pad);
      check($sformatf("vec%0d_addr", i), obs_addr[vecs[i].pos][vecs[i].tap], vecs[i].addr);
      $display("[TB] vector %0d pos=%0d tap=%0d pad=%0d addr=%0d", i, vecs[i].pos, vecs[i].tap,
               obs_pad[vecs[i].pos][vecs[i].tap], obs_addr[vecs[i].pos][vecs[i].tap]);
    end

    // start pulsed while busy at pos 2 must not disturb the pass
    run_pass(0, 2, -1);
    $display("[TB] pass with spurious start complete");

    // random back-pressure including the 5-cycle hold at pos 3
    run_pass(1, -1, -1);
    $display("[TB] pass with random out_ready complete");

    // abort at pos 10 tap 5, then a clean restart
    run_pass(0, -1, 10 * BPP + 5);
    $display("[TB] abort pass complete");
    run_pass(0, -1, -1);
    $display("[TB] restart after abort complete");

    // reset during a stalled commit, then a normal pass
    start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      step();
      k++;
    end
    check("reach_commit", out_valid, 1);
    step();
    reset = 1'b1;
    step();
    check("reset_mid_outs", all_outs(), 0);
    reset = 1'b0;
    run_pass(0, -1, -1);
    ref_tap(0, 0, epad, eaddr);
    check("post_reset_tap0_pad", obs_pad[0][0], epad);
    $display("[TB] reset-during-commit pass complete");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
